// File: rtl/tone_scheduler.sv
// Two-channel note sequencer that time-slices one tone generator.
// Each slot times its own note; the arbiter picks which note reaches fullnote.
module tone_scheduler #(
    parameter int TICK_DIV    = 25000,
    parameter int SLICE_TICKS = 8,
    parameter int DUR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ch0_valid,
    input  logic [5:0]       ch0_note,
    input  logic [DUR_W-1:0] ch0_dur,
    output logic             ch0_ready,
    output logic             ch0_done,
    input  logic             ch1_valid,
    input  logic [5:0]       ch1_note,
    input  logic [DUR_W-1:0] ch1_dur,
    output logic             ch1_ready,
    output logic             ch1_done,
    input  logic             stop,
    output logic [5:0]       fullnote,
    output logic             grant,
    output logic             busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SLICE_TICKS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } slot_t;

    logic [PW-1:0]    presc;
    logic             tick;

    slot_t            state   [2];
    slot_t            state_n [2];
    logic [5:0]       note_q  [2];
    logic [5:0]       note_n  [2];
    logic [DUR_W-1:0] rem_q   [2];
    logic [DUR_W-1:0] rem_n   [2];
    logic [1:0]       done_q;
    logic [1:0]       done_n;

    logic [1:0]       valid;
    logic [5:0]       req_note [2];
    logic [DUR_W-1:0] req_dur  [2];

    logic [1:0]       play_now;
    logic [1:0]       play_nxt;
    logic [SW-1:0]    slice;
    logic [SW-1:0]    slice_n;
    logic             grant_n;
    logic [5:0]       full_n;

    assign valid       = {ch1_valid, ch0_valid};
    assign req_note[0] = ch0_note;
    assign req_note[1] = ch1_note;
    assign req_dur[0]  = ch0_dur;
    assign req_dur[1]  = ch1_dur;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign ch0_ready = (state[0] == IDLE) && !stop;
    assign ch1_ready = (state[1] == IDLE) && !stop;
    assign ch0_done  = done_q[0];
    assign ch1_done  = done_q[1];

    // Slot next-state: stop wins over everything, then expiry or accept.
    always_comb begin
        done_n = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_n[i] = state[i];
            note_n[i]  = note_q[i];
            rem_n[i]   = rem_q[i];
            if (stop) begin
                state_n[i] = IDLE;
            end else begin
                unique case (state[i])
                    IDLE: begin
                        if (valid[i]) begin
                            note_n[i] = req_note[i];
                            rem_n[i]  = req_dur[i];
                            if (req_dur[i] == '0) begin
                                done_n[i] = 1'b1;
                            end else begin
                                state_n[i] = PLAY;
                            end
                        end
                    end
                    PLAY: begin
                        if (tick && rem_q[i] != '0) begin
                            rem_n[i] = rem_q[i] - 1'b1;
                            if (rem_q[i] == DUR_W'(1)) begin
                                state_n[i] = IDLE;
                                done_n[i]  = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign play_now = {state[1] == PLAY, state[0] == PLAY};
    assign play_nxt = {state_n[1] == PLAY, state_n[0] == PLAY};

    // Arbitration looks at next slot state so fullnote lines up with it.
    always_comb begin
        grant_n = grant;
        slice_n = '0;
        unique case (play_nxt)
            2'b01: grant_n = 1'b0;
            2'b10: grant_n = 1'b1;
            2'b11: begin
                if (play_now == 2'b11) begin
                    slice_n = slice;
                    if (tick) begin
                        if (slice == SW'(SLICE_TICKS - 1)) begin
                            grant_n = !grant;
                            slice_n = '0;
                        end else begin
                            slice_n = slice + 1'b1;
                        end
                    end
                end else begin
                    grant_n = (play_now == 2'b10);
                end
            end
            default: ;
        endcase
        full_n = (play_nxt == 2'b00) ? 6'd0 : note_n[grant_n];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state[i]  <= IDLE;
                note_q[i] <= '0;
                rem_q[i]  <= '0;
            end
            done_q   <= 2'b00;
            slice    <= '0;
            grant    <= 1'b0;
            fullnote <= '0;
            busy     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i]  <= state_n[i];
                note_q[i] <= note_n[i];
                rem_q[i]  <= rem_n[i];
            end
            done_q   <= done_n;
            slice    <= slice_n;
            grant    <= grant_n;
            fullnote <= full_n;
            busy     <= |play_nxt;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed scenarios plus random traffic,
// every output compared each cycle against a note-level reference model.
module tb_tone_scheduler;

    localparam int TD  = 4;
    localparam int ST  = 2;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ch0_valid, ch1_valid;
    logic [5:0]    ch0_note, ch1_note;
    logic [DW-1:0] ch0_dur, ch1_dur;
    logic          ch0_ready, ch1_ready;
    logic          ch0_done, ch1_done;
    logic          stop;
    logic [5:0]    fullnote;
    logic          grant;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_cyc;
    bit m_play [2];
    int m_left [2];
    int m_note [2];
    bit m_done [2];
    int m_grant;
    int m_shared;
    int m_full;
    bit m_busy;

    tone_scheduler #(
        .TICK_DIV(TD),
        .SLICE_TICKS(ST),
        .DUR_W(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch0_valid(ch0_valid),
        .ch0_note(ch0_note),
        .ch0_dur(ch0_dur),
        .ch0_ready(ch0_ready),
        .ch0_done(ch0_done),
        .ch1_valid(ch1_valid),
        .ch1_note(ch1_note),
        .ch1_dur(ch1_dur),
        .ch1_ready(ch1_ready),
        .ch1_done(ch1_done),
        .stop(stop),
        .fullnote(fullnote),
        .grant(grant),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_edge(input bit rst, input bit st,
                              input bit v0, input int n0, input int d0,
                              input bit v1, input int n1, input int d1);
        bit tk;
        bit was [2];
        bit vv [2];
        int nn [2];
        int dd [2];
        vv[0] = v0; nn[0] = n0; dd[0] = d0;
        vv[1] = v1; nn[1] = n1; dd[1] = d1;
        if (rst) begin
            m_cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_play[i] = 0; m_left[i] = 0;
                m_note[i] = 0; m_done[i] = 0;
            end
            m_grant = 0; m_shared = 0; m_full = 0; m_busy = 0;
            return;
        end
        tk = (m_cyc % TD) == TD - 1;
        m_cyc++;
        was = m_play;
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            if (st) begin
                m_play[i] = 0;
            end else if (m_play[i]) begin
                if (tk) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_play[i] = 0;
                        m_done[i] = 1;
                    end
                end
            end else if (vv[i]) begin
                if (dd[i] == 0) begin
                    m_done[i] = 1;
                end else begin
                    m_play[i] = 1;
                    m_note[i] = nn[i];
                    m_left[i] = dd[i];
                end
            end
        end
        if (m_play[0] && m_play[1]) begin
            if (was[0] && was[1]) begin
                if (tk) m_shared++;
                if (m_shared == ST) begin
                    m_grant = 1 - m_grant;
                    m_shared = 0;
                end
            end else begin
                m_grant = (was[1] && !was[0]) ? 1 : 0;
                m_shared = 0;
            end
        end else begin
            m_shared = 0;
            if (m_play[0]) m_grant = 0;
            else if (m_play[1]) m_grant = 1;
        end
        m_busy = m_play[0] || m_play[1];
        m_full = m_busy ? m_note[m_grant] : 0;
    endtask

    // One cycle: drive inputs, check ready, clock, check registered outputs.
    task automatic step(input bit rst, input bit st,
                        input bit v0, input int n0, input int d0,
                        input bit v1, input int n1, input int d1);
        reset     = rst;
        stop      = st;
        ch0_valid = v0; ch0_note = 6'(n0); ch0_dur = DW'(d0);
        ch1_valid = v1; ch1_note = 6'(n1); ch1_dur = DW'(d1);
        #1;
        if (!rst) begin
            chk("ch0_ready", ch0_ready, !m_play[0] && !st);
            chk("ch1_ready", ch1_ready, !m_play[1] && !st);
        end
        model_edge(rst, st, v0, n0, d0, v1, n1, d1);
        @(negedge clk);
        chk("fullnote", fullnote, m_full);
        chk("busy", busy, m_busy);
        chk("grant", grant, m_grant);
        chk("ch0_done", ch0_done, m_done[0]);
        chk("ch1_done", ch1_done, m_done[1]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; stop = 1'b0;
        ch0_valid = 1'b0; ch0_note = '0; ch0_dur = '0;
        ch1_valid = 1'b0; ch1_note = '0; ch1_dur = '0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(100);

        step(0, 0, 1, 15, 3, 0, 0, 0);
        chk("t2_first_note", fullnote, 15);
        idle(20);

        step(0, 0, 1, 10, 20, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 30, 20);
        chk("t3_grant_start", grant, 0);
        idle(100);

        step(0, 0, 1, 7, 0, 0, 0, 0);
        chk("t4_done", ch0_done, 1);
        chk("t4_silent", fullnote, 0);
        idle(5);

        step(0, 0, 1, 5, 50, 1, 7, 50);
        idle(10);
        step(0, 1, 1, 9, 9, 1, 9, 9);
        chk("t5_stop_full", fullnote, 0);
        chk("t5_stop_busy", busy, 0);
        idle(5);

        step(0, 0, 0, 0, 0, 1, 0, 4);
        chk("t6_rest_busy", busy, 1);
        idle(25);
        step(0, 0, 1, 9, 10, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 20, 3, 0, 0, 0);
        idle(50);

        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 63),
                 $urandom_range(0, 12),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 63),
                 $urandom_range(0, 12));
        end
        idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
